// File: rtl/spart_rx.sv
// SPART receive engine: 16x-oversampled 8N1 deserialiser with one-byte holding register and sticky status.
// Optional even-parity frame format is enabled with the SPART_RX_PARITY_EN macro.
module spart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_baud_en,
    input  logic                 rxd,
    input  logic                 rd_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rda,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

`ifdef SPART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
    localparam state_e AFTER_DATA = PARITY;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
    localparam state_e AFTER_DATA = STOP;
`endif

    state_e                 state_q;
    logic                   rxd_meta_q, rxd_s_q;
    logic [TICK_W-1:0]      tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]       bit_idx_q;
    logic [DATA_BITS-1:0]   shreg_q, rx_data_q;
    logic                   rda_q, frame_err_q, overrun_q;
    logic                   mid_start, mid_bit;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (rx_baud_en) begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
    end

    assign mid_start = rx_baud_en && (tick_cnt_q == TICK_W'(OVERSAMPLE / 2 - 1));
    assign mid_bit   = rx_baud_en && (tick_cnt_q == TICK_W'(OVERSAMPLE - 1));

`ifdef SPART_RX_PARITY_EN
    logic parity_bit_q, parity_err_q;
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only; later assignments in this block override earlier ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rxd_meta_q  <= 1'b1;
            rxd_s_q     <= 1'b1;
            tick_cnt_q  <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rda_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef SPART_RX_PARITY_EN
            parity_bit_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rxd_meta_q <= rxd;
            rxd_s_q    <= rxd_meta_q;
            tick_cnt_q <= tick_cnt_d;

            if (rd_ack) begin
                rda_q       <= 1'b0;
                overrun_q   <= 1'b0;
                frame_err_q <= 1'b0;
`ifdef SPART_RX_PARITY_EN
                parity_err_q <= 1'b0;
`endif
            end

            case (state_q)
                IDLE: begin
                    if (!rxd_s_q) begin
                        state_q    <= START;
                        tick_cnt_q <= '0;
                    end
                end
                START: begin
                    // A line that is high again at mid start bit was a glitch.
                    if (mid_start) begin
                        if (rxd_s_q) begin
                            state_q <= IDLE;
                        end else begin
                            tick_cnt_q <= '0;
                            bit_idx_q  <= '0;
                            state_q    <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (mid_bit) begin
                        shreg_q   <= {rxd_s_q, shreg_q[DATA_BITS-1:1]};
                        bit_idx_q <= bit_idx_q + BIT_W'(1);
                        if (bit_idx_q == BIT_W'(DATA_BITS - 1)) begin
                            state_q <= AFTER_DATA;
                        end
                    end
                end
`ifdef SPART_RX_PARITY_EN
                PARITY: begin
                    if (mid_bit) begin
                        parity_bit_q <= rxd_s_q;
                        state_q      <= STOP;
                    end
                end
`endif
                STOP: begin
                    // Completion wins over a simultaneous rd_ack; the ack still consumes the old byte.
                    if (mid_bit) begin
                        rx_data_q   <= shreg_q;
                        rda_q       <= 1'b1;
                        frame_err_q <= ~rxd_s_q;
                        overrun_q   <= ~rd_ack & (overrun_q | rda_q);
`ifdef SPART_RX_PARITY_EN
                        parity_err_q <= ^{shreg_q, parity_bit_q};
`endif
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rda       = rda_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_spart_rx.sv
// Directed bench for spart_rx: frames are driven on rxd while a scoreboard holds the expected result
// of each frame, popped and compared on the exact tick at which the frame must complete.
module tb_spart_rx;

    localparam int OS       = 16;
    localparam int DW       = 8;
    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = OS * TICK_DIV;
`ifdef SPART_RX_PARITY_EN
    localparam int FRAME_TICKS = (OS * 3) / 2 + (DW + 1) * OS;
`else
    localparam int FRAME_TICKS = (OS * 3) / 2 + DW * OS;
`endif

    logic          clk = 1'b0;
    logic          rst, rx_baud_en, rxd, rd_ack;
    logic [DW-1:0] rx_data;
    logic          rda, frame_err, overrun, parity_err;

    typedef struct {
        logic [DW-1:0] data;
        logic          fe;
        logic          pe;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   model_rda = 1'b0;
    bit   model_ovr = 1'b0;

    spart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_baud_en (rx_baud_en),
        .rxd        (rxd),
        .rd_ack     (rd_ack),
        .rx_data    (rx_data),
        .rda        (rda),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    // Oversample tick: one clk in every TICK_DIV, changed on the falling edge.
    initial begin
        int phase;
        phase      = 0;
        rx_baud_en = 1'b0;
        forever begin
            @(negedge clk);
            rx_baud_en = (phase == TICK_DIV - 1);
            phase      = (phase + 1) % TICK_DIV;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag, input logic [DW-1:0] data, input logic fe, input logic pe);
        check({tag, "_rx_data"}, 32'(rx_data), 32'(data));
        check({tag, "_rda"}, 32'(rda), 32'(model_rda));
        check({tag, "_frame_err"}, 32'(frame_err), 32'(fe));
        check({tag, "_overrun"}, 32'(overrun), 32'(model_ovr));
        check({tag, "_parity_err"}, 32'(parity_err), 32'(pe));
    endtask

    task automatic drive_frame(input logic [DW-1:0] data, input logic pbit, input int stop_low);
        rxd = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < DW; i++) begin
            rxd = data[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
`ifdef SPART_RX_PARITY_EN
        rxd = pbit;
        repeat (BIT_CLKS) @(negedge clk);
`endif
        rxd = 1'b0;
        repeat (stop_low) @(negedge clk);
        rxd = 1'b1;
        repeat (BIT_CLKS - stop_low) @(negedge clk);
    endtask

    // Counts ticks from start detection (2-flop sync + 1 IDLE clk) and compares at the completion tick.
    task automatic await_completion(input string tag, input bit ack_on_complete);
        exp_t e;
        repeat (3) @(posedge clk);
        for (int n = 0; n < FRAME_TICKS - 1; ) begin
            @(posedge clk);
            if (rx_baud_en) n++;
        end
        repeat (TICK_DIV) @(negedge clk);
        if (!model_rda) check({tag, "_rda_before"}, 32'(rda), 32'(0));
        rd_ack = ack_on_complete;
        @(negedge clk);
        rd_ack = 1'b0;
        e = sb_q.pop_front();
        model_ovr = !ack_on_complete && (model_ovr || model_rda);
        model_rda = 1'b1;
        check_all(tag, e.data, e.fe, e.pe);
    endtask

    task automatic send(input string tag, input logic [DW-1:0] data, input int stop_low,
                        input bit bad_parity, input bit ack_on_complete);
        exp_t e;
        logic pbit;
        pbit   = (^data) ^ bad_parity;
        e.data = data;
        e.fe   = (stop_low > 0);
`ifdef SPART_RX_PARITY_EN
        e.pe   = bad_parity;
`else
        e.pe   = 1'b0;
`endif
        sb_q.push_back(e);
        fork
            drive_frame(data, pbit, stop_low);
            await_completion(tag, ack_on_complete);
        join
    endtask

    task automatic pulse_ack(input string tag, input logic [DW-1:0] data);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack    = 1'b0;
        model_rda = 1'b0;
        model_ovr = 1'b0;
        check_all(tag, data, 1'b0, 1'b0);
    endtask

    initial begin
        rst    = 1'b1;
        rxd    = 1'b1;
        rd_ack = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all("reset", 8'h00, 1'b0, 1'b0);
        repeat (20) @(negedge clk);

        send("a5", 8'hA5, 0, 1'b0, 1'b0);
        repeat (BIT_CLKS) @(negedge clk);

        // Short low pulse: must be rejected as a false start.
        rxd = 1'b0;
        repeat (20) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check_all("glitch", 8'hA5, 1'b0, 1'b0);
        pulse_ack("ack_a5", 8'hA5);

        // Stop bit held low across its sample point, then released.
        send("3c_bad_stop", 8'h3C, 40, 1'b0, 1'b0);
        repeat (2 * BIT_CLKS) @(negedge clk);
        pulse_ack("ack_3c", 8'h3C);
        repeat (BIT_CLKS) @(negedge clk);

        send("b2b_11", 8'h11, 0, 1'b0, 1'b0);
        send("b2b_22", 8'h22, 0, 1'b0, 1'b0);
        send("b2b_11_again", 8'h11, 0, 1'b0, 1'b0);
        send("b2b_22_ack", 8'h22, 0, 1'b0, 1'b1);
        repeat (BIT_CLKS) @(negedge clk);

        // Reset in the middle of the data bits of 0xFF.
        fork
            drive_frame(8'hFF, 1'b0, 0);
            begin
                repeat (BIT_CLKS * 5 + BIT_CLKS / 2) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst       = 1'b0;
                model_rda = 1'b0;
                model_ovr = 1'b0;
                check_all("mid_rst", 8'h00, 1'b0, 1'b0);
            end
        join
        repeat (BIT_CLKS) @(negedge clk);
        send("81_after_rst", 8'h81, 0, 1'b0, 1'b0);
        repeat (BIT_CLKS) @(negedge clk);

        pulse_ack("ack_81", 8'h81);
        send("07_good_par", 8'h07, 0, 1'b0, 1'b0);
        repeat (BIT_CLKS) @(negedge clk);
        send("07_bad_par", 8'h07, 0, 1'b1, 1'b0);
        repeat (BIT_CLKS) @(negedge clk);
        pulse_ack("ack_07", 8'h07);

        check("sb_empty", 32'(sb_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
